// File: rtl/int_fp_acc.sv
// Integer / FP16 accumulator fed by an upstream multiplier. Integer products
// accumulate one per cycle; FP16 products go through a two-cycle align/normalize path.
module int_fp_acc (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic        start,
  input  logic [7:0]  len,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  localparam int DATA_W = 16;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RUN   = 3'd1;
  localparam logic [2:0] ALIGN = 3'd2;
  localparam logic [2:0] NORM  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]        state;
  logic              mode_q;
  logic [7:0]        len_q;
  logic [7:0]        count;
  logic [31:0]       acc;
  logic              accept;
  logic [7:0]        cnt_nxt;

  logic [DATA_W-1:0] opb_p0;
  logic              sgn_big_p1;
  logic              sgn_sml_p1;
  logic [4:0]        exp_big_p1;
  logic [10:0]       man_big_p1;
  logic [10:0]       man_sml_p1;

  logic [14:0]       a_mag;
  logic [14:0]       b_mag;
  logic [15:0]       big_w;
  logic [15:0]       sml_w;
  logic [10:0]       man_big_w;
  logic [10:0]       man_sml_w;
  logic [4:0]        exp_diff;
  logic [11:0]       sum_w;
  logic [15:0]       fp_res;

  // Normalize a 12-bit mantissa sum, truncate, and saturate/flush the exponent.
  function automatic logic [15:0] fp_norm(input logic sign, input logic [4:0] exp,
                                          input logic [11:0] sum);
    logic [3:0]        lead;
    logic [3:0]        sh;
    logic [9:0]        man;
    logic signed [6:0] e;
    lead = 4'd0;
    for (int i = 0; i < 11; i++) begin
      if (sum[i]) lead = 4'(i);
    end
    sh = 4'd10 - lead;
    if (sum[11]) begin
      man = sum[10:1];
      e   = $signed({2'b00, exp}) + 7'sd1;
    end else begin
      man = sum[9:0] << sh;
      e   = $signed({2'b00, exp}) - $signed({3'b000, sh});
    end
    if (sum == 12'd0)      fp_norm = 16'h0000;
    else if (e > 7'sd30)   fp_norm = {sign, 15'h7BFF};
    else if (e < 7'sd1)    fp_norm = 16'h0000;
    else                   fp_norm = {sign, e[4:0], man};
  endfunction

  assign accept  = in_valid && in_ready;
  assign cnt_nxt = count + 8'd1;

  // ALIGN stage: order operands by magnitude and shift the smaller mantissa.
  always_comb begin
    a_mag     = (acc[14:10] == 5'd0) ? 15'd0 : acc[14:0];
    b_mag     = (opb_p0[14:10] == 5'd0) ? 15'd0 : opb_p0[14:0];
    big_w     = (a_mag >= b_mag) ? acc[15:0] : opb_p0;
    sml_w     = (a_mag >= b_mag) ? opb_p0 : acc[15:0];
    man_big_w = (big_w[14:10] == 5'd0) ? 11'd0 : {1'b1, big_w[9:0]};
    man_sml_w = (sml_w[14:10] == 5'd0) ? 11'd0 : {1'b1, sml_w[9:0]};
    exp_diff  = big_w[14:10] - sml_w[14:10];
    if (exp_diff >= 5'd12) man_sml_w = 11'd0;
    else                   man_sml_w = man_sml_w >> exp_diff;
  end

  // NORM stage: add or subtract aligned mantissas, then pack the FP16 result.
  always_comb begin
    if (sgn_big_p1 == sgn_sml_p1) sum_w = {1'b0, man_big_p1} + {1'b0, man_sml_p1};
    else                          sum_w = {1'b0, man_big_p1} - {1'b0, man_sml_p1};
    fp_res = fp_norm(sgn_big_p1, exp_big_p1, sum_w);
  end

  always_ff @(posedge clk) begin
    if (accept) opb_p0 <= in_data;
    if (state == ALIGN) begin
      sgn_big_p1 <= big_w[15];
      sgn_sml_p1 <= sml_w[15];
      exp_big_p1 <= big_w[14:10];
      man_big_p1 <= man_big_w;
      man_sml_p1 <= man_sml_w;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      mode_q <= 1'b0;
      len_q  <= 8'd0;
      count  <= 8'd0;
      acc    <= 32'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mode_q <= mode;
          len_q  <= len;
          acc    <= 32'd0;
          count  <= 8'd0;
          state  <= (len == 8'd0) ? DONE : RUN;
        end
        RUN: if (accept) begin
          count <= cnt_nxt;
          if (mode_q) begin
            state <= ALIGN;
          end else begin
            acc   <= acc + {{(32-DATA_W){1'b0}}, in_data};
            state <= (cnt_nxt == len_q) ? DONE : RUN;
          end
        end
        ALIGN: state <= NORM;
        NORM: begin
          acc   <= {16'h0000, fp_res};
          state <= (count == len_q) ? DONE : RUN;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == RUN);
  assign out_valid = (state == DONE);
  assign out_data  = out_valid ? acc : 32'd0;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_int_fp_acc.sv
// Randomized and directed bench for int_fp_acc against an arithmetic reference model.
module tb_int_fp_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mode = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        busy;

  int errs = 0;
  int checks = 0;
  int lo_pend = 0;
  logic [15:0] stim[$];

  always #5 clk = ~clk;

  int_fp_acc dut (
    .clk(clk), .rst(rst), .mode(mode), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // FP16 add following the block's rules: zero flush, truncated alignment, truncated normalize.
  function automatic logic [15:0] m_fp_add(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, mag_a, mag_b, e_big, e_sml, m_big, m_sml, s_big, s_sml, d, al, r, e;
    logic [15:0] big, sml;
    logic [4:0]  e5;
    logic [9:0]  f;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    mag_a = (ea == 0) ? 0 : int'(a[14:0]);
    mag_b = (eb == 0) ? 0 : int'(b[14:0]);
    if (mag_a >= mag_b) begin big = a; sml = b; end
    else begin big = b; sml = a; end
    e_big = int'(big[14:10]);
    e_sml = int'(sml[14:10]);
    m_big = (e_big == 0) ? 0 : 1024 + int'(big[9:0]);
    m_sml = (e_sml == 0) ? 0 : 1024 + int'(sml[9:0]);
    s_big = int'(big[15]);
    s_sml = int'(sml[15]);
    d  = e_big - e_sml;
    al = (d >= 12) ? 0 : m_sml / (1 << d);
    r  = (s_big == s_sml) ? m_big + al : m_big - al;
    if (r == 0) return 16'h0000;
    e = e_big;
    while (r >= 2048) begin r = r / 2; e++; end
    while (r < 1024) begin r = r * 2; e--; end
    if (e > 30) return (s_big != 0) ? 16'hFBFF : 16'h7BFF;
    if (e < 1) return 16'h0000;
    e5 = e[4:0];
    f  = r[9:0];
    return {big[15], e5, f};
  endfunction

  function automatic logic [31:0] model(input bit m);
    logic [31:0] s;
    logic [15:0] fp;
    s = 32'd0;
    fp = 16'h0000;
    foreach (stim[i]) begin
      s  = s + {16'h0000, stim[i]};
      fp = m_fp_add(fp, stim[i]);
    end
    return m ? {16'h0000, fp} : s;
  endfunction

  task automatic tick();
    @(negedge clk);
    if (lo_pend > 0) begin
      chk("fp_in_ready_low", {31'd0, in_ready}, 32'd0);
      lo_pend--;
    end
  endtask

  task automatic run_job(input bit m, input bit gaps, input int hold, input bit hs_start,
                         input logic [31:0] want);
    int n, idx, cyc, w;
    n = stim.size();
    start = 1'b1; mode = m; len = 8'(n);
    tick();
    start = 1'b0; mode = 1'($urandom); len = 8'($urandom);
    idx = 0; cyc = 0;
    while (idx < n && cyc < 500) begin
      if (in_ready && (!gaps || $urandom_range(3) != 0)) begin
        in_valid = 1'b1; in_data = stim[idx]; idx++;
        if (m) lo_pend = 2;
      end else begin
        in_valid = in_ready ? 1'b0 : 1'($urandom);
        in_data  = 16'($urandom);
      end
      tick();
      cyc++;
    end
    if (cyc >= 500) chk("accept_timeout", 32'(idx), 32'(n));
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 50) begin tick(); w++; end
    chk("out_valid", {31'd0, out_valid}, 32'd1);
    chk("done_latency", 32'(w), (m && n > 0) ? 32'd2 : 32'd0);
    chk("in_ready_done", {31'd0, in_ready}, 32'd0);
    chk("busy_done", {31'd0, busy}, 32'd1);
    chk("out_data", out_data, want);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0; start = 1'($urandom);
      tick();
      chk("held_valid", {31'd0, out_valid}, 32'd1);
      chk("held_data", out_data, want);
    end
    start = hs_start; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; start = 1'b0;
    chk("idle_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_data", out_data, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit m;
    int n;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    stim = '{16'h00FF, 16'h0100, 16'hFE01}; run_job(0, 0, 0, 0, 32'h0001_0000);
    stim = '{16'h3C00, 16'h4000};           run_job(1, 0, 0, 0, 32'h0000_4200);
    stim = '{16'h3C00, 16'hBC00};           run_job(1, 0, 0, 0, 32'h0000_0000);
    stim = '{16'h7BFF, 16'h7BFF};           run_job(1, 0, 0, 0, 32'h0000_7BFF);
    stim = '{16'hFBFF, 16'hFBFF};           run_job(1, 0, 0, 0, 32'h0000_FBFF);
    stim = '{16'h0600, 16'h8400};           run_job(1, 0, 0, 0, 32'h0000_0000);
    stim = '{16'h3C00, 16'h0123};           run_job(1, 0, 0, 0, 32'h0000_3C00);
    stim = '{16'h6000, 16'h3C00};           run_job(1, 0, 0, 0, 32'h0000_6002);
    stim = '{16'h6000, 16'h3400};           run_job(1, 0, 0, 0, 32'h0000_6000);
    stim.delete();                          run_job(0, 0, 0, 0, 32'h0000_0000);
    stim.delete();                          run_job(1, 0, 0, 0, 32'h0000_0000);
    stim = '{16'h1234};                     run_job(0, 0, 5, 1, 32'h0000_1234);

    // Abort a job mid-flight with reset, then run a fresh job.
    start = 1'b1; mode = 1'b0; len = 8'd3;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 16'h0007;
    tick();
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_out_data", out_data, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    stim = '{16'h0005};                     run_job(0, 0, 0, 0, 32'h0000_0005);

    repeat (30) begin
      m = 1'($urandom);
      n = $urandom_range(0, 6);
      stim.delete();
      for (int i = 0; i < n; i++) stim.push_back(16'($urandom));
      run_job(m, 1, $urandom_range(0, 3), 1'($urandom), model(m));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/int_fp_acc.md
INT_FP_ACC -- requirements
Module: int_fp_acc

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst  input  1  asynchronous active-low reset.
REQ-004 Port: mode  input  1  1 = FP16 accumulate, 0 = unsigned integer accumulate; sampled only on an accepted start.
REQ-005 Port: start  input  1  single-cycle pulse that begins an accumulation job.
REQ-006 Port: len  input  8  number of products in the job; sampled only on an accepted start.
REQ-007 Port: in_valid  input  1  in_data is valid.
REQ-008 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-009 Port: in_data  input  16  product word from the upstream multiplier (FP16, or 16-bit unsigned integer).
REQ-010 Port: out_valid  output  1  out_data holds a completed job result.
REQ-011 Port: out_ready  input  1  downstream consumes the result.
REQ-012 Port: out_data  output  32  integer sum, or {16'h0, FP16 sum} in FP mode.
REQ-013 Port: busy  output  1  high in every state except IDLE.

Function
REQ-014 States SHALL be IDLE, RUN, ALIGN, NORM and DONE.
REQ-015 IDLE: start=1 SHALL latch mode and len, clear acc and count, and go to RUN, or go to DONE if len=0.
REQ-016 start SHALL be ignored in every state except IDLE.
REQ-017 in_ready SHALL equal 1 only in RUN, and an input is accepted only when in_valid and in_ready are both high.
REQ-018 Integer mode: on acceptance at cycle t, acc[31:0] SHALL equal acc + zero-extended in_data at t+1, with modulo-2^32 wrap.
REQ-019 Integer mode: the block SHALL stay in RUN after each acceptance, so one input can be accepted per cycle.
REQ-020 FP mode: acceptance at cycle t SHALL enter ALIGN at t+1 and NORM at t+2, then RUN or DONE at t+3, with in_ready=0 in ALIGN and NORM.
REQ-021 ALIGN SHALL swap the operands so the larger magnitude is first and right-shift the smaller {1,mant} by the exponent difference.
REQ-022 Bits shifted out in ALIGN SHALL be discarded (truncation), and a difference of 12 or more SHALL reduce the smaller operand to 0.
REQ-023 NORM SHALL add or subtract the aligned mantissas, normalize with a 1-bit right shift or an n-bit left shift, truncate, and write the FP16 accumulator.
REQ-024 Any FP16 operand with exponent field 0 SHALL be treated as zero, and exponent 31 SHALL be treated as an ordinary value.
REQ-025 A result exponent above 30 SHALL saturate to 0x7BFF or 0xFBFF according to sign.
REQ-026 A result exponent below 1, or exact cancellation, SHALL give +0 (0x0000).
REQ-027 The FP accumulator SHALL start at +0, and adding x to +0 SHALL give x, flushed per REQ-024.
REQ-028 count SHALL increment per accepted input, and the block SHALL go to DONE on the update in which count reaches len.
REQ-029 DONE: out_valid=1 with stable out_data until out_ready=1, then the block SHALL return to IDLE on the next cycle.
REQ-030 A start arriving in the same cycle as the out_ready handshake SHALL be ignored.
REQ-031 out_data SHALL be 0 whenever out_valid=0.

Reset
REQ-032 rst=0 SHALL force IDLE immediately and clear acc, count, the latched mode and the latched len.
REQ-033 During reset all outputs SHALL be 0, namely in_ready, out_valid, out_data and busy.
REQ-034 A reset in the middle of a job SHALL abort it with no out_valid, and a new start after reset release SHALL behave as from power-up.

Verification
REQ-035 Integer test: mode=0, len=3, inputs 0x00FF, 0x0100, 0xFE01 back-to-back -> out_valid one cycle after the 3rd acceptance, out_data=0x00010000.
REQ-036 FP addition test: mode=1, len=2, inputs 0x3C00, 0x4000 -> out_data=0x00004200, in_ready low for 2 cycles after each acceptance.
REQ-037 FP cancellation and overflow test: mode=1, len=2, inputs 0x3C00, 0xBC00 -> 0x00000000; and inputs 0x7BFF, 0x7BFF -> 0x00007BFF.
REQ-038 Empty job test: start with len=0 -> out_valid=1 on the cycle after start, out_data=0, in_ready never asserted.
REQ-039 Backpressure test: hold out_ready=0 for 5 cycles in DONE and pulse start -> out_data held stable, start ignored, return to IDLE after out_ready.
REQ-040 Reset test: mode=0, len=3, 1 input accepted, then rst=0 -> outputs 0 at once; after release, a new len=1 job with input 0x0005 -> out_data=0x00000005.
